fifo_flagged: RTL and testbench

- Parametrised synchronous FIFO; next generation of the UART-path FIFO.
- Adds a true occupancy count and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags and correct simultaneous read/write at every fill level.
- Sits between the UART RX/TX engines and the command/console logic; one clock domain.

---
 rtl/fifo_flagged.sv | 142 ++++++++++++++
 tb/tb_fifo_flagged.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flagged.sv
// fifo_flagged: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Optional build macro FIFO_FWFT_EN selects first-word fall-through read data;
// without it read_data_out is a register loaded on each accepted read.
module fifo_flagged #(
  parameter int unsigned DATA_SIZE        = 8,
  parameter int unsigned ADDR_SPACE_EXP   = 6,
  parameter int unsigned ALMOST_FULL_LVL  = 2**ADDR_SPACE_EXP - 4,
  parameter int unsigned ALMOST_EMPTY_LVL = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      write_to_fifo,
  input  logic                      read_from_fifo,
  input  logic [DATA_SIZE-1:0]      write_data_in,
  output logic [DATA_SIZE-1:0]      read_data_out,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic [ADDR_SPACE_EXP:0]   fill_count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clear_err
);

  localparam int unsigned DEPTH = 2**ADDR_SPACE_EXP;
  localparam int unsigned CW    = ADDR_SPACE_EXP + 1;

  localparam logic [CW-1:0]             DepthC   = CW'(DEPTH);
  localparam logic [CW-1:0]             AfLvl    = CW'(ALMOST_FULL_LVL);
  localparam logic [CW-1:0]             AeLvl    = CW'(ALMOST_EMPTY_LVL);
  localparam logic [CW-1:0]             CountOne = CW'(1);
  localparam logic [ADDR_SPACE_EXP-1:0] PtrOne   = ADDR_SPACE_EXP'(1);

  logic [DATA_SIZE-1:0]      mem_q [DEPTH];
  logic [ADDR_SPACE_EXP-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SPACE_EXP-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      empty_q, empty_d;
  logic                      full_q, full_d;
  logic                      almost_empty_q, almost_empty_d;
  logic                      almost_full_q, almost_full_d;
  logic                      overflow_q, overflow_d;
  logic                      underflow_q, underflow_d;
  logic                      wr_acc, rd_acc;

  // Accept decisions use the registered flags; a full FIFO still takes a
  // write when a read frees a slot on the same edge.
  always_comb begin
    wr_acc = write_to_fifo & (~full_q | read_from_fifo);
    rd_acc = read_from_fifo & ~empty_q;
  end

  // Next-state pointers, count, flags and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PtrOne;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PtrOne;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
    empty_d        = (count_d == '0);
    full_d         = (count_d == DepthC);
    almost_empty_d = (count_d <= AeLvl);
    almost_full_d  = (count_d >= AfLvl);
    // Set wins over a same-cycle clear.
    overflow_d  = (overflow_q & ~clear_err) | (write_to_fifo & full_q & ~read_from_fifo);
    underflow_d = (underflow_q & ~clear_err) | (read_from_fifo & empty_q);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= write_data_in;
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through; forced to zero while nothing valid is stored.
  always_comb begin
    read_data_out = empty_q ? '0 : mem_q[rd_ptr_q];
  end
`else
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;

  // Read register loads the head word on an accepted read, holds otherwise.
  always_comb begin
    rdata_d = rd_acc ? mem_q[rd_ptr_q] : rdata_q;
  end

  // Read data register with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  // Drive the output port from the read register.
  always_comb begin
    read_data_out = rdata_q;
  end
`endif

  // Drive the remaining output ports from the registered state.
  always_comb begin
    empty        = empty_q;
    full         = full_q;
    almost_empty = almost_empty_q;
    almost_full  = almost_full_q;
    fill_count   = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_fifo_flagged.sv
// Directed testbench for fifo_flagged (DEPTH 64, default thresholds).
// Handles both read-data timings selected by FIFO_FWFT_EN.
module tb_fifo_flagged;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       write_to_fifo, read_from_fifo, clear_err;
  logic [7:0] write_data_in;
  logic [7:0] read_data_out;
  logic       empty, full, almost_empty, almost_full;
  logic [6:0] fill_count;
  logic       overflow, underflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fifo_flagged dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .write_to_fifo  (write_to_fifo),
    .read_from_fifo (read_from_fifo),
    .write_data_in  (write_data_in),
    .read_data_out  (read_data_out),
    .empty          (empty),
    .full           (full),
    .almost_empty   (almost_empty),
    .almost_full    (almost_full),
    .fill_count     (fill_count),
    .overflow       (overflow),
    .underflow      (underflow),
    .clear_err      (clear_err)
  );

  // One clock with the given inputs; returns 1ns after the edge.
  task automatic op(input logic w, input logic r, input logic [7:0] d, input logic clr);
    write_to_fifo  = w;
    read_from_fifo = r;
    write_data_in  = d;
    clear_err      = clr;
    @(posedge clk);
    #1;
    write_to_fifo  = 1'b0;
    read_from_fifo = 1'b0;
    clear_err      = 1'b0;
  endtask

  // Accepted read; returns the word delivered by that read.
  task automatic pop(output logic [7:0] d);
`ifdef FIFO_FWFT_EN
    d = read_data_out;
    op(1'b0, 1'b1, 8'h00, 1'b0);
`else
    op(1'b0, 1'b1, 8'h00, 1'b0);
    d = read_data_out;
`endif
  endtask

  task automatic test_reset();
    total_cnt++; if (fill_count !== 7'd0) $display("FAIL reset_count got %0d want 0", fill_count); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else pass_cnt++;
    total_cnt++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else pass_cnt++;
    total_cnt++; if (almost_empty !== 1'b1) $display("FAIL reset_ae got %b want 1", almost_empty); else pass_cnt++;
    total_cnt++; if (almost_full !== 1'b0) $display("FAIL reset_af got %b want 0", almost_full); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL reset_err got ovf=%b udf=%b want 0 0", overflow, underflow); else pass_cnt++;
    total_cnt++; if (read_data_out !== 8'h00) $display("FAIL reset_rdata got %h want 00", read_data_out); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    op(1'b0, 1'b1, 8'h00, 1'b0);  // read at empty -> underflow
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
    total_cnt++; if (fill_count !== 7'd5 || underflow !== 1'b1)
      $display("FAIL mid_pre got cnt=%0d udf=%b want 5 1", fill_count, underflow); else pass_cnt++;
    #3 reset_n = 1'b0;
    #1;
    total_cnt++; if (fill_count !== 7'd0 || empty !== 1'b1 || almost_empty !== 1'b1)
      $display("FAIL mid_rst got cnt=%0d e=%b ae=%b want 0 1 1", fill_count, empty, almost_empty); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL mid_rst_err got ovf=%b udf=%b want 0 0", overflow, underflow); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    op(1'b1, 1'b0, 8'h77, 1'b0);
    pop(d);
    total_cnt++; if (d !== 8'h77) $display("FAIL mid_newword got %h want 77", d); else pass_cnt++;
  endtask

  task automatic test_fill_drain();
    logic [7:0] d;
    for (int i = 0; i < 64; i++) begin
      op(1'b1, 1'b0, 8'(i), 1'b0);
      if (i == 3) begin
        total_cnt++; if (almost_empty !== 1'b1) $display("FAIL ae_at4 got %b want 1", almost_empty); else pass_cnt++;
      end
      if (i == 4) begin
        total_cnt++; if (almost_empty !== 1'b0) $display("FAIL ae_at5 got %b want 0", almost_empty); else pass_cnt++;
      end
      if (i == 58) begin
        total_cnt++; if (almost_full !== 1'b0) $display("FAIL af_at59 got %b want 0", almost_full); else pass_cnt++;
      end
      if (i == 59) begin
        total_cnt++; if (almost_full !== 1'b1) $display("FAIL af_at60 got %b want 1", almost_full); else pass_cnt++;
      end
    end
    total_cnt++; if (full !== 1'b1 || fill_count !== 7'd64)
      $display("FAIL fill_full got full=%b cnt=%0d want 1 64", full, fill_count); else pass_cnt++;
    for (int i = 0; i < 64; i++) begin
      pop(d);
      total_cnt++; if (d !== 8'(i)) $display("FAIL drain_%0d got %h want %h", i, d, 8'(i)); else pass_cnt++;
    end
    total_cnt++; if (empty !== 1'b1 || fill_count !== 7'd0)
      $display("FAIL drain_empty got e=%b cnt=%0d want 1 0", empty, fill_count); else pass_cnt++;
    // Offset pointers by 10 so the next full pass wraps.
    for (int i = 0; i < 10; i++) op(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      pop(d);
      total_cnt++; if (d !== 8'(8'h80 + i)) $display("FAIL off_%0d got %h want %h", i, d, 8'(8'h80 + i)); else pass_cnt++;
    end
    for (int i = 0; i < 64; i++) op(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    total_cnt++; if (full !== 1'b1) $display("FAIL wrap_full got %b want 1", full); else pass_cnt++;
    for (int i = 0; i < 64; i++) begin
      pop(d);
      total_cnt++; if (d !== 8'(8'hC0 + i)) $display("FAIL wrap_%0d got %h want %h", i, d, 8'(8'hC0 + i)); else pass_cnt++;
    end
    total_cnt++; if (empty !== 1'b1) $display("FAIL wrap_empty got %b want 1", empty); else pass_cnt++;
  endtask

  task automatic test_full_rw();
    logic [7:0] d;
    for (int i = 0; i < 64; i++) op(1'b1, 1'b0, 8'(i), 1'b0);
    op(1'b1, 1'b1, 8'hA5, 1'b0);
    total_cnt++; if (fill_count !== 7'd64 || full !== 1'b1 || overflow !== 1'b0)
      $display("FAIL full_rw got cnt=%0d full=%b ovf=%b want 64 1 0", fill_count, full, overflow); else pass_cnt++;
`ifdef FIFO_FWFT_EN
    total_cnt++; if (read_data_out !== 8'h01) $display("FAIL full_rw_head got %h want 01", read_data_out); else pass_cnt++;
`else
    total_cnt++; if (read_data_out !== 8'h00) $display("FAIL full_rw_rdata got %h want 00", read_data_out); else pass_cnt++;
`endif
    for (int i = 1; i < 64; i++) begin
      pop(d);
      total_cnt++; if (d !== 8'(i)) $display("FAIL full_rw_%0d got %h want %h", i, d, 8'(i)); else pass_cnt++;
    end
    pop(d);
    total_cnt++; if (d !== 8'hA5) $display("FAIL full_rw_last got %h want a5", d); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL full_rw_empty got %b want 1", empty); else pass_cnt++;
  endtask

  task automatic test_empty_rw();
    logic [7:0] d;
    op(1'b1, 1'b1, 8'h3C, 1'b0);
    total_cnt++; if (underflow !== 1'b1 || fill_count !== 7'd1 || empty !== 1'b0)
      $display("FAIL empty_rw got udf=%b cnt=%0d e=%b want 1 1 0", underflow, fill_count, empty); else pass_cnt++;
    op(1'b0, 1'b0, 8'h00, 1'b1);
    pop(d);
    total_cnt++; if (d !== 8'h3C) $display("FAIL empty_rw_data got %h want 3c", d); else pass_cnt++;
    total_cnt++; if (underflow !== 1'b0 || empty !== 1'b1)
      $display("FAIL empty_rw_after got udf=%b e=%b want 0 1", underflow, empty); else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [7:0] d;
    for (int i = 0; i < 64; i++) op(1'b1, 1'b0, 8'(i), 1'b0);
    op(1'b1, 1'b0, 8'h11, 1'b0);
    total_cnt++; if (overflow !== 1'b1 || fill_count !== 7'd64)
      $display("FAIL ovf_set got ovf=%b cnt=%0d want 1 64", overflow, fill_count); else pass_cnt++;
    // Same-cycle clear and new overflow: flag must stay set.
    op(1'b1, 1'b0, 8'h22, 1'b1);
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_setwins got %b want 1", overflow); else pass_cnt++;
    for (int i = 0; i < 64; i++) begin
      pop(d);
      total_cnt++; if (d !== 8'(i)) $display("FAIL ovf_drain_%0d got %h want %h", i, d, 8'(i)); else pass_cnt++;
    end
    total_cnt++; if (empty !== 1'b1) $display("FAIL ovf_drain_empty got %b want 1", empty); else pass_cnt++;
    op(1'b0, 1'b0, 8'h00, 1'b1);
    total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else pass_cnt++;
    op(1'b0, 1'b1, 8'h00, 1'b0);
    total_cnt++; if (underflow !== 1'b1 || fill_count !== 7'd0)
      $display("FAIL udf_set got udf=%b cnt=%0d want 1 0", underflow, fill_count); else pass_cnt++;
    op(1'b0, 1'b1, 8'h00, 1'b1);
    total_cnt++; if (underflow !== 1'b1) $display("FAIL udf_setwins got %b want 1", underflow); else pass_cnt++;
    op(1'b0, 1'b0, 8'h00, 1'b1);
    total_cnt++; if (underflow !== 1'b0) $display("FAIL udf_clear got %b want 0", underflow); else pass_cnt++;
  endtask

  task automatic test_fwft();
    logic [7:0] d;
    op(1'b1, 1'b0, 8'h11, 1'b0);
`ifdef FIFO_FWFT_EN
    total_cnt++; if (read_data_out !== 8'h11) $display("FAIL fwft_head got %h want 11", read_data_out); else pass_cnt++;
`else
    // Register still holds the last word drained by the previous test.
    total_cnt++; if (read_data_out !== 8'h3F) $display("FAIL std_hold got %h want 3f", read_data_out); else pass_cnt++;
`endif
    pop(d);
    total_cnt++; if (d !== 8'h11) $display("FAIL fwft_read got %h want 11", d); else pass_cnt++;
    op(1'b0, 1'b0, 8'h00, 1'b0);
`ifdef FIFO_FWFT_EN
    total_cnt++; if (read_data_out !== 8'h00) $display("FAIL fwft_empty got %h want 00", read_data_out); else pass_cnt++;
`else
    total_cnt++; if (read_data_out !== 8'h11) $display("FAIL std_hold2 got %h want 11", read_data_out); else pass_cnt++;
`endif
  endtask

  initial begin
    reset_n        = 1'b0;
    write_to_fifo  = 1'b0;
    read_from_fifo = 1'b0;
    clear_err      = 1'b0;
    write_data_in  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset_mid();
    test_fill_drain();
    test_full_rw();
    test_empty_rw();
    test_errors();
    test_fwft();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
